// File: rtl/cnt_chk_pkg.sv
// Shared encodings for the counter-sequence checker: code modes, FSM states,
// per-mode modulus and the johnson code table.
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_RING = 2'b01,
        MODE_JOHN = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_e;

    // Modulus needs 5 bits so binary mode can hold 16.
    localparam logic [4:0] MOD_BIN  = 5'd16;
    localparam logic [4:0] MOD_RING = 5'd4;
    localparam logic [4:0] MOD_JOHN = 5'd8;

    localparam logic [3:0] JOHNSON_TBL [8] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

endpackage

// File: rtl/cnt_code_decode.sv
// Combinational decode of a 4-bit counter code into sequence index, legality
// flag and the modulus of the selected code type.
module cnt_code_decode
    import cnt_chk_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] code,
    output logic [3:0] index,
    output logic       legal,
    output logic [4:0] modulus
);

    always_comb begin
        index   = 4'd0;
        legal   = 1'b0;
        modulus = MOD_BIN;
        case (mode_e'(mode))
            MODE_BIN: begin
                index   = code;
                legal   = 1'b1;
                modulus = MOD_BIN;
            end
            MODE_RING: begin
                modulus = MOD_RING;
                case (code)
                    4'b0001: begin index = 4'd0; legal = 1'b1; end
                    4'b0010: begin index = 4'd1; legal = 1'b1; end
                    4'b0100: begin index = 4'd2; legal = 1'b1; end
                    4'b1000: begin index = 4'd3; legal = 1'b1; end
                    default: ;
                endcase
            end
            MODE_JOHN: begin
                modulus = MOD_JOHN;
                for (int k = 0; k < 8; k++) begin
                    if (code == JOHNSON_TBL[k]) begin
                        index = 4'(k);
                        legal = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cnt_seq_checker.sv
// Counter-sequence checker: decodes binary/ring/johnson codes, tracks lock on
// consecutive legal steps, flags errors while locked. Build option: CNT_CHK_HOLD_EN.
//
// state | meaning
// HUNT  | no reference index; next legal code becomes the reference
// ACQ   | counting consecutive legal steps toward LOCK_CNT
// LOCK  | sequence tracked; any illegal code/step raises o_err
module cnt_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic [3:0]       i_cnt,
    output logic [3:0]       o_index,
    output logic             o_index_valid,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int SW = $clog2(LOCK_CNT + 1);

    state_e        state;
    logic [3:0]    prev_index;
    logic [SW-1:0] step_cnt;
    logic [1:0]    last_mode;

    logic [3:0]    dec_index;
    logic          legal;
    logic [4:0]    modulus;
    logic [4:0]    prev_inc;
    logic [4:0]    exp_next;
    logic          step_ok;
    logic          is_hold;
    logic          mode_chg;
    logic [SW-1:0] step_nxt;

    cnt_code_decode u_decode (
        .mode    (i_mode),
        .code    (i_cnt),
        .index   (dec_index),
        .legal   (legal),
        .modulus (modulus)
    );

    always_comb begin
        prev_inc = {1'b0, prev_index} + 5'd1;
        exp_next = (prev_inc == modulus) ? 5'd0 : prev_inc;
        step_ok  = legal && ({1'b0, dec_index} == exp_next);
        step_nxt = step_cnt + SW'(1);
        // In HUNT there is no trustworthy reference mode, so a mode change is moot.
        mode_chg = (state != HUNT) && (i_mode != last_mode);
`ifdef CNT_CHK_HOLD_EN
        is_hold  = legal && (dec_index == prev_index);
`else
        is_hold  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            prev_index    <= 4'd0;
            step_cnt      <= '0;
            last_mode     <= 2'b00;
            o_index       <= 4'd0;
            o_index_valid <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_index_valid <= 1'b0;
            o_err         <= 1'b0;
            if (i_valid) begin
                last_mode <= i_mode;
                // Every legal code becomes the new reference, including wrong steps.
                if (legal) begin
                    o_index       <= dec_index;
                    o_index_valid <= 1'b1;
                    prev_index    <= dec_index;
                end
                if (mode_chg) begin
                    state    <= HUNT;
                    step_cnt <= '0;
                    o_locked <= 1'b0;
                end else begin
                    case (state)
                        HUNT: begin
                            if (legal) begin
                                state    <= ACQ;
                                step_cnt <= '0;
                            end
                        end
                        ACQ: begin
                            if (is_hold) begin
                                state <= ACQ;
                            end else if (step_ok) begin
                                step_cnt <= step_nxt;
                                if (step_nxt == SW'(LOCK_CNT)) begin
                                    state    <= LOCK;
                                    o_locked <= 1'b1;
                                end
                            end else begin
                                state <= HUNT;
                            end
                        end
                        LOCK: begin
                            if (!is_hold && !step_ok) begin
                                state    <= HUNT;
                                o_locked <= 1'b0;
                                o_err    <= 1'b1;
                                if (o_err_cnt != '1)
                                    o_err_cnt <= o_err_cnt + ERR_W'(1);
                            end
                        end
                        default: begin
                            state    <= HUNT;
                            o_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed bench for cnt_seq_checker with hand-computed expectations;
// follows CNT_CHK_HOLD_EN for the repeated-sample case.
module tb_cnt_seq_checker;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic [1:0] i_mode;
    logic [3:0] i_cnt;
    logic [3:0] o_index;
    logic       o_index_valid;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_errs = 0;

    cnt_seq_checker #(.LOCK_CNT(4), .ERR_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_mode        (i_mode),
        .i_cnt         (i_cnt),
        .o_index       (o_index),
        .o_index_valid (o_index_valid),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_err_cnt     (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] c);
        @(negedge clk);
        i_valid = 1'b1;
        i_mode  = m;
        i_cnt   = c;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic err_event();
        exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_errs = 0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_mode  = 2'b00;
        i_cnt   = 4'd0;
        #12;
        chk("rst_index", 32'(o_index), 0);
        chk("rst_index_valid", 32'(o_index_valid), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_err_cnt", 32'(o_err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // binary 0..15,0..3: lock after the 5th sample, no error across the wrap
        for (int k = 0; k < 20; k++) begin
            send(2'b00, 4'(k % 16));
            chk("bin_locked", 32'(o_locked), (k >= 4) ? 1 : 0);
            chk("bin_index", 32'(o_index), k % 16);
            chk("bin_err", 32'(o_err), 0);
        end
        chk("bin_err_cnt", 32'(o_err_cnt), 0);

        // idle cycles change nothing
        idle(); idle(); idle();
        chk("idle_index_valid", 32'(o_index_valid), 0);
        chk("idle_locked", 32'(o_locked), 1);
        chk("idle_index", 32'(o_index), 3);

        // repeated sample while locked
        reset_all();
        for (int k = 0; k < 5; k++) send(2'b00, 4'(k));
        chk("rep_pre_locked", 32'(o_locked), 1);
        send(2'b00, 4'd5);
        send(2'b00, 4'd5);
`ifdef CNT_CHK_HOLD_EN
        chk("rep_err", 32'(o_err), 0);
        chk("rep_locked", 32'(o_locked), 1);
        chk("rep_index_valid", 32'(o_index_valid), 1);
`else
        err_event();
        chk("rep_err", 32'(o_err), 1);
        chk("rep_locked", 32'(o_locked), 0);
`endif
        chk("rep_err_cnt", 32'(o_err_cnt), 32'(exp_errs));
        for (int k = 6; k <= 10; k++) send(2'b00, 4'(k));
        chk("relock_bin", 32'(o_locked), 1);

        // mode switch while locked: back to HUNT, no error
        send(2'b10, 4'b0000);
        chk("msw_locked", 32'(o_locked), 0);
        chk("msw_err", 32'(o_err), 0);
        chk("msw_err_cnt", 32'(o_err_cnt), 32'(exp_errs));

        // johnson lock, wrap 7->0, then illegal code 0101
        send(2'b10, 4'b0001);
        send(2'b10, 4'b0011);
        send(2'b10, 4'b0111);
        send(2'b10, 4'b1111);
        send(2'b10, 4'b1110);
        chk("john_locked", 32'(o_locked), 1);
        send(2'b10, 4'b1100);
        send(2'b10, 4'b1000);
        send(2'b10, 4'b0000);
        chk("john_wrap_err", 32'(o_err), 0);
        chk("john_wrap_index", 32'(o_index), 0);
        send(2'b10, 4'b0001);
        chk("john_wrap_locked", 32'(o_locked), 1);
        send(2'b10, 4'b0101);
        err_event();
        chk("john_bad_err", 32'(o_err), 1);
        chk("john_bad_err_cnt", 32'(o_err_cnt), 32'(exp_errs));
        chk("john_bad_locked", 32'(o_locked), 0);
        chk("john_bad_index", 32'(o_index), 1);
        chk("john_bad_index_valid", 32'(o_index_valid), 0);
        idle();
        chk("john_err_pulse", 32'(o_err), 0);

        // ring lock, wrong-step error reloads to index 0, relock
        send(2'b01, 4'b0001);
        send(2'b01, 4'b0010);
        send(2'b01, 4'b0100);
        send(2'b01, 4'b1000);
        send(2'b01, 4'b0001);
        chk("ring_locked", 32'(o_locked), 1);
        send(2'b01, 4'b0010);
        send(2'b01, 4'b0100);
        chk("ring_index", 32'(o_index), 2);
        send(2'b01, 4'b0001);
        err_event();
        chk("ring_bad_err", 32'(o_err), 1);
        chk("ring_bad_locked", 32'(o_locked), 0);
        chk("ring_bad_index", 32'(o_index), 0);
        chk("ring_bad_err_cnt", 32'(o_err_cnt), 32'(exp_errs));
        send(2'b01, 4'b0010);
        send(2'b01, 4'b0100);
        send(2'b01, 4'b1000);
        send(2'b01, 4'b0001);
        chk("ring_relock_err", 32'(o_err), 0);
        send(2'b01, 4'b0010);
        chk("ring_relocked", 32'(o_locked), 1);

        // reserved mode: leaves LOCK quietly, then holds in HUNT
        send(2'b11, 4'b0001);
        chk("rsvd_exit_err", 32'(o_err), 0);
        chk("rsvd_exit_locked", 32'(o_locked), 0);
        for (int k = 0; k < 6; k++) send(2'b11, 4'(k));
        chk("rsvd_locked", 32'(o_locked), 0);
        chk("rsvd_index_valid", 32'(o_index_valid), 0);
        chk("rsvd_index", 32'(o_index), 1);

        // error counter saturation
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 5; k++) send(2'b00, 4'(k));
            send(2'b00, 4'd9);
            err_event();
        end
        chk("sat_err", 32'(o_err), 1);
        chk("sat_err_cnt", 32'(o_err_cnt), 255);

        // asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) send(2'b00, 4'(k));
        chk("pre_rst_locked", 32'(o_locked), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_index", 32'(o_index), 0);
        chk("arst_locked", 32'(o_locked), 0);
        chk("arst_err_cnt", 32'(o_err_cnt), 0);
        chk("arst_index_valid", 32'(o_index_valid), 0);
        chk("arst_err", 32'(o_err), 0);
        @(negedge clk);
        rst = 1'b0;
        send(2'b00, 4'd7);
        chk("post_rst_index", 32'(o_index), 7);
        chk("post_rst_locked", 32'(o_locked), 0);
        for (int k = 8; k <= 11; k++) send(2'b00, 4'(k));
        chk("post_rst_relock", 32'(o_locked), 1);
        chk("post_rst_err_cnt", 32'(o_err_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
